loop_replay: RTL

LOOP_REPLAY -- requirements
Module: loop_replay

---
 rtl/loop_replay_pkg.sv | 19 +
 rtl/loop_store_ram.sv | 26 ++
 rtl/loop_replay.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/loop_replay_pkg.sv
// Shared definitions for the loop replay buffer: FSM encoding, sizing defaults
// and the instruction constants used by the capture side.
package loop_replay_pkg;

    localparam int DEPTH_DEFAULT = 8;
    localparam int IDX_W_DEFAULT = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_PRIME  = 2'd2;
    localparam logic [1:0] ST_REPLAY = 2'd3;

    // RV32 major opcodes of the instructions that can close a loop body.
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_BTYPE = 7'b1100011;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/loop_store_ram.sv
// Loop body storage: one write port, one registered read port, DEPTH x 32.
module loop_store_ram
    import loop_replay_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH];

    // NOTE: neither the array nor the read register is reset; the top gates
    // rd_data with its own reset-cleared state, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/loop_replay.sv
// Loop replay buffer: captures a short loop body, then replays it to decode
// while stalling fetch, until the loop-exit branch resolves as a mispredict.
module loop_replay
    import loop_replay_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_valid,
    input  logic [31:0] cap_instr,
    input  logic [31:0] cap_pc,
    input  logic        cap_last,
    input  logic        cap_abort,
    input  logic        mispredict,
    input  logic        rep_ready,
    output logic        rep_valid,
    output logic [31:0] rep_instr,
    output logic [31:0] rep_pc,
    output logic        block_signal,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        overflow,
    output logic [15:0] iter_count
);

    localparam logic [IDX_W:0]   LEN_ONE  = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] wptr;
    logic [IDX_W-1:0] rptr;
    logic [IDX_W:0]   len;
    logic [31:0]      base_pc;
    logic [31:0]      rd_data;

    logic             accept;
    logic             wrap;
    logic             wr_en;
    logic             rd_en;
    logic [IDX_W-1:0] wr_addr;
    logic [IDX_W-1:0] rd_addr;

    assign rep_valid    = (state == ST_REPLAY);
    assign block_signal = (state == ST_PRIME) || (state == ST_REPLAY);
    assign accept       = rep_valid && rep_ready && !mispredict;
    assign wrap         = (({1'b0, rptr} + LEN_ONE) == len);

    assign overflow = (state == ST_FILL) && cap_valid && !cap_abort && !cap_last
                      && (wptr == IDX_LAST);

    assign wr_en   = cap_valid && ((state == ST_IDLE)
                     || ((state == ST_FILL) && !cap_abort && !overflow));
    assign wr_addr = (state == ST_IDLE) ? '0 : wptr;

    // Read the entry rptr will point at after this edge, so data and pointer
    // move together and back-to-back accepts stream one instruction per cycle.
    assign rd_en   = (state == ST_PRIME) || accept;
    assign rd_addr = ((state == ST_PRIME) || wrap) ? '0 : rptr + IDX_ONE;

    assign rep_instr = rep_valid ? rd_data : '0;
    assign rep_pc    = rep_valid ? base_pc + PC_INC * 32'(rptr) : '0;
    assign flush     = rep_valid && mispredict;
    assign new_pc    = flush ? base_pc + PC_INC * 32'(len) : '0;

    loop_store_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_store (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (cap_instr),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wptr       <= '0;
            rptr       <= '0;
            len        <= '0;
            base_pc    <= '0;
            iter_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cap_valid) begin
                        base_pc <= cap_pc;
                        wptr    <= IDX_ONE;
                        if (cap_last) begin
                            len   <= LEN_ONE;
                            state <= ST_PRIME;
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (cap_abort) begin
                        wptr  <= '0;
                        state <= ST_IDLE;
                    end else if (cap_valid) begin
                        if (cap_last) begin
                            len   <= {1'b0, wptr} + LEN_ONE;
                            wptr  <= wptr + IDX_ONE;
                            state <= ST_PRIME;
                        end else if (wptr == IDX_LAST) begin
                            wptr  <= '0;
                            state <= ST_IDLE;
                        end else begin
                            wptr <= wptr + IDX_ONE;
                        end
                    end
                end
                ST_PRIME: begin
                    rptr       <= '0;
                    iter_count <= '0;
                    state      <= ST_REPLAY;
                end
                ST_REPLAY: begin
                    if (mispredict) begin
                        state <= ST_IDLE;
                    end else if (rep_ready) begin
                        if (wrap) begin
                            rptr <= '0;
                            if (iter_count != 16'hFFFF) iter_count <= iter_count + 16'd1;
                        end else begin
                            rptr <= rptr + IDX_ONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
